// File: rtl/gic_slave_mw.sv
// gic_slave_mw: GIC link slave bridging request frames onto a classic Wishbone master.
//
// Receives a request frame over LANES 4-bit lanes and validates its checksum.
// It then runs one Wishbone cycle, guarded by a watchdog, and returns a
// checksummed response frame that carries a status code.
//
// Ports:
//   wbm_clk_i, wbm_rst_i       clock, asynchronous active-high reset
//   wbm_adr_o/dat_o/sel_o/we_o Wishbone request, held stable through the cycle
//   wbm_cyc_o/stb_o            asserted for the whole Wishbone cycle
//   wbm_cti_o/bte_o            classic cycle, constant zero
//   wbm_dat_i, wbm_ack_i/err_i/rty_i  read data and cycle termination
//   gic_dat_i / gic_dat_o      link receive / registered link transmit (W = 4*LANES)
module gic_slave_mw #(
  parameter int unsigned LANES   = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 wbm_clk_i,
  input  logic                 wbm_rst_i,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  input  logic [4*LANES-1:0]   gic_dat_i,
  output logic [4*LANES-1:0]   gic_dat_o
);

  localparam int unsigned W    = 4 * LANES;
  localparam int unsigned NSYM = 32 / W;

  localparam logic [W-1:0] RepInit = {LANES{4'b1010}};
  localparam logic [W-1:0] RepRsp  = {LANES{4'b0101}};
  localparam logic [W-1:0] RepCk   = {LANES{4'b1100}};

  localparam logic [3:0] CodeAck   = 4'b0000;
  localparam logic [3:0] CodeErr   = 4'b0001;
  localparam logic [3:0] CodeRty   = 4'b0010;
  localparam logic [3:0] CodeBadck = 4'b0011;
  localparam logic [3:0] CodeTout  = 4'b0100;

  typedef enum logic [3:0] {
    StIdle, StCmd, StSel, StAdr, StDat, StCk, StWb, StRinit, StResp, StRdat, StRck
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  dat_q, dat_d;
  logic [3:0]   sel_q, sel_d;
  logic         we_q, we_d;
  logic [W-1:0] ck_q, ck_d;
  logic [3:0]   code_q, code_d;
  logic [31:0]  rdat_q, rdat_d;
  logic [31:0]  wd_q, wd_d;
  logic [W-1:0] tx_q, tx_d;

  logic [W-1:0] resp_sym;
  logic [W-1:0] rdat_sym;
  logic         last_sym;

  assign resp_sym = W'(code_q);
  assign rdat_sym = rdat_q[31 -: W];
  assign last_sym = (cnt_q == 4'(NSYM - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ck_d    = ck_q;
    code_d  = code_q;
    rdat_d  = rdat_q;
    wd_d    = wd_q;
    tx_d    = '1;
    case (state_q)
      StIdle: begin
        if (gic_dat_i == RepInit) state_d = StCmd;
      end
      StCmd: begin
        we_d    = gic_dat_i[3];
        ck_d    = gic_dat_i;
        state_d = StSel;
      end
      StSel: begin
        sel_d   = gic_dat_i[3:0];
        ck_d    = ck_q ^ gic_dat_i;
        cnt_d   = '0;
        state_d = StAdr;
      end
      StAdr: begin
        // Shift left by a whole symbol; at W = 32 the shift clears the register.
        adr_d = (adr_q << W) | 32'(gic_dat_i);
        ck_d  = ck_q ^ gic_dat_i;
        if (last_sym) begin
          cnt_d   = '0;
          state_d = we_q ? StDat : StCk;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDat: begin
        dat_d = (dat_q << W) | 32'(gic_dat_i);
        ck_d  = ck_q ^ gic_dat_i;
        if (last_sym) begin
          cnt_d   = '0;
          state_d = StCk;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCk: begin
        wd_d = '0;
        if (gic_dat_i == (ck_q ^ RepCk)) begin
          state_d = StWb;
        end else begin
          code_d  = CodeBadck;
          state_d = StRinit;
        end
      end
      StWb: begin
        wd_d = wd_q + 32'd1;
        // A termination on the expiry cycle takes precedence over the timeout.
        if (wbm_err_i) begin
          code_d  = CodeErr;
          state_d = StRinit;
        end else if (wbm_rty_i) begin
          code_d  = CodeRty;
          state_d = StRinit;
        end else if (wbm_ack_i) begin
          code_d  = CodeAck;
          rdat_d  = wbm_dat_i;
          state_d = StRinit;
        end else if (TIMEOUT != 0 && wd_d == TIMEOUT) begin
          code_d  = CodeTout;
          state_d = StRinit;
        end
      end
      StRinit: begin
        tx_d    = RepRsp;
        state_d = StResp;
      end
      StResp: begin
        tx_d    = resp_sym;
        ck_d    = resp_sym ^ RepCk;
        cnt_d   = '0;
        state_d = (!we_q && code_q == CodeAck) ? StRdat : StRck;
      end
      StRdat: begin
        tx_d   = rdat_sym;
        ck_d   = ck_q ^ rdat_sym;
        rdat_d = rdat_q << W;
        if (last_sym) begin
          cnt_d   = '0;
          state_d = StRck;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRck: begin
        tx_d    = ck_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
    if (wbm_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ck_q    <= '0;
      code_q  <= '0;
      rdat_q  <= '0;
      wd_q    <= '0;
      tx_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ck_q    <= ck_d;
      code_q  <= code_d;
      rdat_q  <= rdat_d;
      wd_q    <= wd_d;
      tx_q    <= tx_d;
    end
  end

  // Cycle strobes follow the state register so reset drops them without a clock edge.
  assign wbm_cyc_o = (state_q == StWb);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign gic_dat_o = tx_q;

endmodule

// File: tb/tb_gic_slave_mw.sv
module tb_gic_slave_mw;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LANES=1, TIMEOUT=4 instance
  logic [31:0] adr1, dato1, rdata1;
  logic [3:0]  sel1, din1, dout1;
  logic        we1, cyc1, stb1, ack1, err1, rty1;
  logic [2:0]  cti1;
  logic [1:0]  bte1;
  logic        ack_en1, err_en1, rty_en1;

  assign ack1 = cyc1 & ack_en1;
  assign err1 = cyc1 & err_en1;
  assign rty1 = cyc1 & rty_en1;

  gic_slave_mw #(.LANES(1), .TIMEOUT(4)) u_dut1 (
    .wbm_clk_i(clk), .wbm_rst_i(rst),
    .wbm_adr_o(adr1), .wbm_dat_o(dato1), .wbm_sel_o(sel1), .wbm_we_o(we1),
    .wbm_cyc_o(cyc1), .wbm_stb_o(stb1), .wbm_cti_o(cti1), .wbm_bte_o(bte1),
    .wbm_dat_i(rdata1), .wbm_ack_i(ack1), .wbm_err_i(err1), .wbm_rty_i(rty1),
    .gic_dat_i(din1), .gic_dat_o(dout1)
  );

  // LANES=4, default TIMEOUT instance
  logic [31:0] adr4, dato4, rdata4;
  logic [3:0]  sel4;
  logic [15:0] din4, dout4;
  logic        we4, cyc4, stb4, ack4, err4, rty4;
  logic [2:0]  cti4;
  logic [1:0]  bte4;
  logic        ack_en4, err_en4;

  assign ack4 = cyc4 & ack_en4;
  assign err4 = cyc4 & err_en4;
  assign rty4 = 1'b0;

  gic_slave_mw #(.LANES(4)) u_dut4 (
    .wbm_clk_i(clk), .wbm_rst_i(rst),
    .wbm_adr_o(adr4), .wbm_dat_o(dato4), .wbm_sel_o(sel4), .wbm_we_o(we4),
    .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_cti_o(cti4), .wbm_bte_o(bte4),
    .wbm_dat_i(rdata4), .wbm_ack_i(ack4), .wbm_err_i(err4), .wbm_rty_i(rty4),
    .gic_dat_i(din4), .gic_dat_o(dout4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Wishbone monitors
  int          cyc_cnt1 = 0;
  int          cyc_cnt4 = 0;
  logic [31:0] cap_adr1, cap_dat1, cap_adr4;
  logic [3:0]  cap_sel1;
  logic        cap_we1, cap_we4;

  always @(negedge clk) begin
    if (cyc1) begin
      cyc_cnt1 = cyc_cnt1 + 1;
      cap_adr1 = adr1;
      cap_dat1 = dato1;
      cap_sel1 = sel1;
      cap_we1  = we1;
    end
    if (cyc4) begin
      cyc_cnt4 = cyc_cnt4 + 1;
      cap_adr4 = adr4;
      cap_we4  = we4;
    end
  end

  logic [3:0] frm [0:19];
  logic [3:0] r1  [0:15];
  logic [3:0] ex  [0:15];
  int         lat;

  // Drives one symbol per cycle starting in the current (negedge) cycle.
  task automatic send1(input int n);
    for (int i = 0; i < n; i++) begin
      din1 = frm[i];
      @(negedge clk);
    end
    din1 = 4'hF;
  endtask

  // Waits for the response INIT, records n symbols, then checks the idle that follows.
  task automatic collect1(input int n);
    lat = 1;
    while (dout1 !== 4'h5 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (dout1 !== 4'h5) begin
      n_bad++;
      $display("FAIL resp_init_wait: dout=%h required 5 within 60 cycles", dout1);
    end
    for (int i = 0; i < n; i++) begin
      r1[i] = dout1;
      @(negedge clk);
    end
    n_cmp++;
    if (dout1 !== 4'hF) begin
      n_bad++;
      $display("FAIL idle_after_rck: dout=%h required f", dout1);
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (dout1 !== 4'hF)    begin n_bad++; $display("FAIL rst_dout1: got %h want f", dout1); end
    n_cmp++; if (dout4 !== 16'hFFFF) begin n_bad++; $display("FAIL rst_dout4: got %h want ffff", dout4); end
    n_cmp++; if (cyc1 !== 1'b0 || stb1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_cyc1: got cyc=%b stb=%b want 0 0", cyc1, stb1);
    end
    n_cmp++; if (cyc4 !== 1'b0 || stb4 !== 1'b0) begin
      n_bad++; $display("FAIL rst_cyc4: got cyc=%b stb=%b want 0 0", cyc4, stb4);
    end
    n_cmp++; if (we1 !== 1'b0 || we4 !== 1'b0) begin
      n_bad++; $display("FAIL rst_we: got %b %b want 0 0", we1, we4);
    end
    n_cmp++; if (adr1 !== 32'h0 || dato1 !== 32'h0 || sel1 !== 4'h0) begin
      n_bad++; $display("FAIL rst_regs1: got adr=%h dat=%h sel=%h want 0", adr1, dato1, sel1);
    end
    n_cmp++; if (adr4 !== 32'h0 || dato4 !== 32'h0 || sel4 !== 4'h0) begin
      n_bad++; $display("FAIL rst_regs4: got adr=%h dat=%h sel=%h want 0", adr4, dato4, sel4);
    end
    n_cmp++; if (cti1 !== 3'b000 || bte1 !== 2'b00 || cti4 !== 3'b000 || bte4 !== 2'b00) begin
      n_bad++; $display("FAIL rst_cti_bte: got %b %b %b %b want 0", cti1, bte1, cti4, bte4);
    end
  endtask

  task automatic load_write;
    frm = '{4'hA, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0,
            4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF, 4'hA};
  endtask

  task automatic load_read;
    frm = '{4'hA, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0,
            4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  endtask

  task automatic check_write_done(input string tag);
    ex = '{4'h5, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
           4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (r1[i] !== ex[i]) begin
        n_bad++; $display("FAIL %s resp[%0d]: got %h want %h", tag, i, r1[i], ex[i]);
      end
    end
    n_cmp++;
    if (cap_we1 !== 1'b1 || cap_adr1 !== 32'h00001000 || cap_dat1 !== 32'hDEADBEEF ||
        cap_sel1 !== 4'hF) begin
      n_bad++;
      $display("FAIL %s wb_req: got we=%b adr=%h dat=%h sel=%h want 1 00001000 deadbeef f",
               tag, cap_we1, cap_adr1, cap_dat1, cap_sel1);
    end
  endtask

  task automatic test_write;
    cyc_cnt1 = 0;
    load_write();
    send1(20);
    collect1(3);
    check_write_done("write");
    n_cmp++; if (cyc_cnt1 !== 1) begin n_bad++; $display("FAIL write_cyc_len: got %0d want 1", cyc_cnt1); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d want 3", lat); end
  endtask

  task automatic test_read;
    cyc_cnt1 = 0;
    rdata1 = 32'h12345678;
    load_read();
    send1(12);
    collect1(11);
    ex = '{4'h5, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
           4'h7, 4'h8, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (r1[i] !== ex[i]) begin
        n_bad++; $display("FAIL read resp[%0d]: got %h want %h", i, r1[i], ex[i]);
      end
    end
    n_cmp++;
    if (cap_we1 !== 1'b0 || cap_adr1 !== 32'h00000040 || cyc_cnt1 !== 1) begin
      n_bad++;
      $display("FAIL read_wb_req: got we=%b adr=%h cycles=%0d want 0 00000040 1",
               cap_we1, cap_adr1, cyc_cnt1);
    end
  endtask

  task automatic test_badck;
    cyc_cnt1 = 0;
    load_write();
    frm[19] = 4'hB;
    send1(20);
    collect1(3);
    ex = '{4'h5, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
           4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (r1[i] !== ex[i]) begin
        n_bad++; $display("FAIL badck resp[%0d]: got %h want %h", i, r1[i], ex[i]);
      end
    end
    n_cmp++; if (cyc_cnt1 !== 0) begin n_bad++; $display("FAIL badck_no_cyc: got %0d want 0", cyc_cnt1); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL badck_latency: got %0d want 2", lat); end
  endtask

  task automatic test_timeout;
    cyc_cnt1 = 0;
    ack_en1 = 1'b0;
    load_write();
    send1(20);
    collect1(3);
    ack_en1 = 1'b1;
    ex = '{4'h5, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
           4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (r1[i] !== ex[i]) begin
        n_bad++; $display("FAIL timeout resp[%0d]: got %h want %h", i, r1[i], ex[i]);
      end
    end
    n_cmp++; if (cyc_cnt1 !== 4) begin n_bad++; $display("FAIL timeout_cyc_len: got %0d want 4", cyc_cnt1); end
  endtask

  task automatic test_back_to_back;
    cyc_cnt1 = 0;
    load_write();
    send1(20);
    collect1(3);
    check_write_done("b2b_write");
    // collect1 returns in the cycle right after RCK was on the wire
    rdata1 = 32'hA5A50F0F;
    load_read();
    send1(12);
    collect1(11);
    // resp 0; data a,5,a,5,0,f,0,f xor to 0; rck = 0 ^ c = c
    ex = '{4'h5, 4'h0, 4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'hF,
           4'h0, 4'hF, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (r1[i] !== ex[i]) begin
        n_bad++; $display("FAIL b2b_read resp[%0d]: got %h want %h", i, r1[i], ex[i]);
      end
    end
    n_cmp++; if (cyc_cnt1 !== 2) begin n_bad++; $display("FAIL b2b_cycles: got %0d want 2", cyc_cnt1); end
  endtask

  task automatic test_lanes4_err;
    logic [15:0] f4 [0:5];
    logic [15:0] e4 [0:2];
    logic [15:0] g4 [0:2];
    int          l4;
    f4 = '{16'hAAAA, 16'h0000, 16'h000F, 16'hCAFE, 16'hF00D, 16'hF630};
    e4 = '{16'h5555, 16'h0001, 16'hCCCD};
    cyc_cnt4 = 0;
    rdata4 = 32'hCAFEF00D;
    ack_en4 = 1'b1;
    err_en4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din4 = f4[i];
      @(negedge clk);
    end
    din4 = 16'hFFFF;
    l4 = 1;
    while (dout4 !== 16'h5555 && l4 < 60) begin
      @(negedge clk);
      l4++;
    end
    for (int i = 0; i < 3; i++) begin
      g4[i] = dout4;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (g4[i] !== e4[i]) begin
        n_bad++; $display("FAIL lanes4 resp[%0d]: got %h want %h", i, g4[i], e4[i]);
      end
    end
    n_cmp++; if (dout4 !== 16'hFFFF) begin n_bad++; $display("FAIL lanes4_idle: got %h want ffff", dout4); end
    n_cmp++;
    if (cap_adr4 !== 32'hCAFEF00D || cap_we4 !== 1'b0 || cyc_cnt4 !== 1) begin
      n_bad++;
      $display("FAIL lanes4_wb_req: got adr=%h we=%b cycles=%0d want cafef00d 0 1",
               cap_adr4, cap_we4, cyc_cnt4);
    end
    err_en4 = 1'b0;
  endtask

  task automatic test_reset_in_wb;
    ack_en1 = 1'b0;
    load_write();
    send1(20);
    n_cmp++; if (cyc1 !== 1'b1) begin n_bad++; $display("FAIL rwb_cyc_up: got %b want 1", cyc1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cyc1 !== 1'b0 || stb1 !== 1'b0) begin
      n_bad++; $display("FAIL rwb_cyc_drop: got cyc=%b stb=%b want 0 0", cyc1, stb1);
    end
    n_cmp++; if (dout1 !== 4'hF) begin n_bad++; $display("FAIL rwb_dout: got %h want f", dout1); end
    @(negedge clk);
    rst = 1'b0;
    ack_en1 = 1'b1;
    @(negedge clk);
    cyc_cnt1 = 0;
    send1(20);
    collect1(3);
    check_write_done("after_reset");
    n_cmp++; if (cyc_cnt1 !== 1) begin n_bad++; $display("FAIL after_reset_cycles: got %0d want 1", cyc_cnt1); end
  endtask

  initial begin
    din1 = 4'hF;   din4 = 16'hFFFF;
    rdata1 = '0;   rdata4 = '0;
    ack_en1 = 1'b1; err_en1 = 1'b0; rty_en1 = 1'b0;
    ack_en4 = 1'b1; err_en4 = 1'b0;
    #2 rst = 1'b1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_write();
    test_read();
    test_badck();
    test_timeout();
    test_back_to_back();
    test_lanes4_err();
    test_reset_in_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gic_slave_mw.md
# gic_slave_mw

Parametrised Gris InterConnect slave: receives GIC request frames over a link of 4-bit lanes, validates the frame checksum, runs one classic Wishbone master cycle with a watchdog timeout, and returns a checksummed response frame with a status code. It sits at the far end of a GIC link, bridging onto a local Wishbone bus. It is the multi-lane successor of the single-nibble GIC slave.

## Interface

Parameters:
- LANES, 1: link lanes, one of 1/2/4/8; link width W = 4*LANES; NSYM = 32/W symbols per address or data word.
- TIMEOUT, 255: Wishbone watchdog in cycles; 0 disables the watchdog.

Ports:
- wbm_clk_i in 1: clock; all logic on rising edge.
- wbm_rst_i in 1: reset; asynchronous, active-high.
- wbm_adr_o out 32: Wishbone address.
- wbm_dat_o out 32: write data.
- wbm_sel_o out 4: byte select.
- wbm_we_o out 1: write enable.
- wbm_cyc_o / wbm_stb_o out 1 each: cycle/strobe; always equal.
- wbm_cti_o out 3: constant 3'b000.
- wbm_bte_o out 2: constant 2'b00.
- wbm_dat_i in 32: read data.
- wbm_ack_i / wbm_err_i / wbm_rty_i in 1 each: cycle termination.
- gic_dat_i in W: link receive; lane k = bits [4k+3:4k].
- gic_dat_o out W: link transmit, registered.

## Operation

- Symbol = one W-bit link word per clock. REP(x) = nibble x replicated on all lanes. Idle = all ones.
- Request frame: INIT = REP(4'b1010); CMD (lane0 bit3 = we, remaining bits unused); SEL (lane0 = sel); NSYM ADR symbols, MS symbol first; NSYM DAT symbols (writes only); CK.
- Request checksum: XOR of CMD, SEL, all ADR and all DAT symbols, then XOR REP(4'b1100). CK must equal it.
- States: IDLE, CMD, SEL, ADR, DAT, CK, WB, RINIT, RESP, RDAT, RCK.
  - IDLE -> CMD only when every lane equals 1010. INIT patterns inside a frame are treated as data.
  - ADR -> DAT (we = 1) or CK (we = 0) after NSYM symbols. DAT -> CK after NSYM symbols.
  - CK -> WB on a checksum match. On a mismatch CK -> RINIT with code BADCK, and no Wishbone cycle is issued.
  - WB -> RINIT on ack/err/rty or on timeout.
  - RINIT -> RESP -> RDAT (read with code ACK) or RCK. RDAT -> RCK after NSYM symbols. RCK -> IDLE.
- Response codes (lane0 of RESP; other lanes 0): 0000 ACK, 0001 ERR, 0010 RTY, 0011 BADCK, 0100 TIMEOUT.
- Termination priority when several are asserted together: err, then rty, then ack.
- Response frame: REP(4'b0101), RESP, NSYM data symbols (read ACK only; wbm_dat_i captured on the ack edge, MS first), RCK.
- RCK = XOR of RESP and the data symbols, then XOR REP(4'b1100).
- gic_dat_i is ignored in the states WB through RCK.
- Address, data, sel and we registers load during frame receive. They are held stable for the whole WB state.
- Watchdog counter clears on entry to WB and increments each WB cycle. When it reaches TIMEOUT, cyc/stb drop and the code is TIMEOUT. A termination in the same cycle as expiry wins over the timeout.

## Timing

- Reset values:
  - wbm_cyc_o/stb_o/we_o = 0; adr/dat/sel = 0.
  - gic_dat_o = all ones.
  - State IDLE.
- Asserting reset mid-cycle drops cyc/stb immediately (asynchronous) and aborts any frame. No response is sent.
- wbm_cyc_o rises on the clock edge that samples CK. It falls on the edge that samples a termination or timeout.
- gic_dat_o carries INIT in the cycle after termination, RESP one cycle later, and so on. Each symbol is held exactly one cycle. Idle is driven in the cycle after RCK.
- A BADCK response starts in the cycle after CK.
- Back-to-back: a new INIT is accepted in the cycle after RCK has been transmitted.
- Frame lengths:
  - Write request: 4 + 2*NSYM symbols (20 at LANES=1, 6 at LANES=8).
  - Read request: 4 + NSYM symbols.
  - Read ACK response: 3 + NSYM symbols; every other response is 3 symbols.
- Zero-wait slave (ack in the first WB cycle): INIT out appears 2 cycles after CK is sampled.

## Test plan

- LANES=1 write: cmd 8, sel F, adr 0x00001000, data 0xDEADBEEF, CK 0xA.
  - Required: one Wishbone cycle with we=1, adr 0x00001000, dat 0xDEADBEEF, sel F.
  - Response with ack: 5, 0, C.
- LANES=1 read: adr 0x00000040, slave returns 0x12345678 with ack.
  - Required response: 5, 0, 1,2,3,4,5,6,7,8, 4.
- LANES=1 write frame with CK deliberately wrong (0xB).
  - Required: wbm_cyc_o never asserts; response 5, 3, F.
- TIMEOUT=4, slave never terminates.
  - Required: cyc high exactly 4 cycles; response 5, 4, 8.
- LANES=4 read of 0xCAFEF00D with err and ack asserted together.
  - Required: code ERR, no data; response 0x5555, 0x0001, 0xCCCD.
- Reset asserted while in WB: cyc drops with no clock edge and gic_dat_o = all ones. The next valid frame is then processed normally.
